// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALU operation codes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ILLEGAL
  } ctrl_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

  // Only add/sub, slt, or and and are implemented for R and I types.
  function automatic logic alu_funct3_ok(input logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b010) ||
           (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the control FSM and the unified instruction/data memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/alu_decode.sv
// Combinational ALU-control decode from the main FSM's alu_op and instruction fields.
module alu_decode
  import ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over a shared ALU and unified memory.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               op,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     zero,
  multicycle_ctrl_if.master        mem,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     reg_write,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               result_src,
  output logic [1:0]               imm_src,
  output logic [2:0]               alu_ctrl,
  output logic                     instr_done,
  output logic                     illegal
);

  ctrl_state_t state, state_nxt;
  alu_op_t     alu_op;
  logic [2:0]  alu_ctrl_dec;
  logic        c_mem_req, c_mem_write, c_adr_src, c_ir_write, c_pc_write, c_reg_write;
  logic        c_instr_done, c_illegal;
  logic [1:0]  c_src_a, c_src_b, c_result_src;

  alu_decode u_alu_decode (
    .alu_op   (alu_op),
    .op5      (op[5]),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (alu_ctrl_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    alu_op       = ALUOP_ADD;
    c_mem_req    = 1'b0;
    c_mem_write  = 1'b0;
    c_adr_src    = 1'b0;
    c_ir_write   = 1'b0;
    c_pc_write   = 1'b0;
    c_reg_write  = 1'b0;
    c_instr_done = 1'b0;
    c_illegal    = 1'b0;
    c_src_a      = SRCA_PC;
    c_src_b      = SRCB_RS2;
    c_result_src = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        c_mem_req    = 1'b1;
        c_src_b      = SRCB_FOUR;
        c_result_src = RES_ALU;
        if (mem.mem_ready) begin
          c_ir_write = 1'b1;
          c_pc_write = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        c_src_a = SRCA_OLDPC;
        c_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:      state_nxt = alu_funct3_ok(funct3) ? S_EXECR : S_ILLEGAL;
          OP_I:      state_nxt = alu_funct3_ok(funct3) ? S_EXECI : S_ILLEGAL;
          OP_BRANCH: state_nxt = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
          OP_JAL:    state_nxt = S_JAL;
          default:   state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        c_src_a   = SRCA_RS1;
        c_src_b   = SRCB_IMM;
        state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        c_mem_req = 1'b1;
        c_adr_src = 1'b1;
        if (mem.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c_result_src = RES_DATA;
        c_reg_write  = 1'b1;
        c_instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        c_mem_req   = 1'b1;
        c_adr_src   = 1'b1;
        c_mem_write = mem.mem_ready;
        if (mem.mem_ready) begin
          c_instr_done = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_EXECR: begin
        c_src_a   = SRCA_RS1;
        c_src_b   = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        c_src_a   = SRCA_RS1;
        c_src_b   = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        c_result_src = RES_ALUOUT;
        c_reg_write  = 1'b1;
        c_instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BEQ: begin
        c_src_a      = SRCA_RS1;
        c_src_b      = SRCB_RS2;
        alu_op       = ALUOP_SUB;
        c_pc_write   = zero;
        c_instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_JAL: begin
        // ALUOut already holds the jump target from DECODE; compute PC+4 for rd.
        c_src_a    = SRCA_OLDPC;
        c_src_b    = SRCB_FOUR;
        c_pc_write = 1'b1;
        state_nxt  = S_ALUWB;
      end
      S_ILLEGAL: c_illegal = 1'b1;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Every output is held low while reset is asserted, regardless of state.
  always_comb begin
    mem.mem_req   = rst_n & c_mem_req;
    mem.mem_write = rst_n & c_mem_write;
    mem.adr_src   = rst_n & c_adr_src;
    ir_write      = rst_n & c_ir_write;
    pc_write      = rst_n & c_pc_write;
    reg_write     = rst_n & c_reg_write;
    instr_done    = rst_n & c_instr_done;
    illegal       = rst_n & c_illegal;
    alu_src_a     = rst_n ? c_src_a      : '0;
    alu_src_b     = rst_n ? c_src_b      : '0;
    result_src    = rst_n ? c_result_src : '0;
    imm_src       = rst_n ? imm_src_of(op) : '0;
    alu_ctrl      = rst_n ? alu_ctrl_dec : '0;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written corner sequences and
// randomized instructions checked cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       ir_write, pc_write, reg_write, instr_done, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_ctrl;

  multicycle_ctrl_if mif ();

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem        (mif.master),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_ctrl   (alu_ctrl),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b, res, imm;
    logic [2:0] alu;
    logic       done, ill;
  } outs_t;

  typedef struct {
    logic  care;
    logic  mr;
    outs_t e;
  } cyc_t;

  typedef struct {
    string       nm;
    logic [31:0] ir;
    logic        z;
    int          fw;
    int          mw;
    int          cycles;
  } vec_t;

  cyc_t q[$];
  int   total = 0;
  int   bad = 0;

  function automatic outs_t got();
    outs_t g;
    g.mem_req = mif.mem_req;   g.mem_write = mif.mem_write; g.adr_src = mif.adr_src;
    g.ir_write = ir_write;     g.pc_write = pc_write;       g.reg_write = reg_write;
    g.a = alu_src_a;           g.b = alu_src_b;             g.res = result_src;
    g.imm = imm_src;           g.alu = alu_ctrl;            g.done = instr_done;
    g.ill = illegal;
    return g;
  endfunction

  task automatic chk(input string nm, input outs_t e);
    outs_t g;
    g = got();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, g, e);
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, g, e);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // 0 load, 1 store, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
  function automatic int cls(input logic [6:0] o, input logic [2:0] f3);
    logic f3ok;
    f3ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return f3ok ? 2 : 6;
      7'b0010011: return f3ok ? 3 : 6;
      7'b1100011: return (f3 == 3'd0) ? 4 : 6;
      7'b1101111: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic rtype, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (rtype && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outs_t blank(input logic [1:0] imm);
    outs_t e;
    e = '0;
    e.imm = imm;
    return e;
  endfunction

  function automatic void push(input logic care, input logic mr, input outs_t e);
    cyc_t c;
    c.care = care;
    c.mr   = mr;
    c.e    = e;
    q.push_back(c);
  endfunction

  task automatic build(input logic [31:0] ir, input logic z, input int fw, input int mw,
                       input int ill_cycles);
    logic [6:0] o;
    logic [2:0] f3;
    logic [1:0] imm;
    int         c;
    outs_t      e;
    o   = ir[6:0];
    f3  = ir[14:12];
    imm = exp_imm(o);
    c   = cls(o, f3);
    e = blank(imm); e.mem_req = 1'b1; e.b = 2'b10; e.res = 2'b10;
    for (int i = 0; i < fw; i++) push(1'b1, 1'b0, e);
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b1, 1'b1, e);
    e = blank(imm); e.a = 2'b01; e.b = 2'b01;
    push(1'b0, 1'b0, e);
    case (c)
      0, 1: begin
        e = blank(imm); e.a = 2'b10; e.b = 2'b01;
        push(1'b0, 1'b0, e);
        e = blank(imm); e.mem_req = 1'b1; e.adr_src = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b1, 1'b0, e);
        if (c == 0) begin
          push(1'b1, 1'b1, e);
          e = blank(imm); e.res = 2'b01; e.reg_write = 1'b1; e.done = 1'b1;
          push(1'b0, 1'b0, e);
        end else begin
          e.mem_write = 1'b1; e.done = 1'b1;
          push(1'b1, 1'b1, e);
        end
      end
      2, 3: begin
        e = blank(imm); e.a = 2'b10; e.b = (c == 2) ? 2'b00 : 2'b01;
        e.alu = exp_alu(c == 2, f3, ir[30]);
        push(1'b0, 1'b0, e);
        e = blank(imm); e.reg_write = 1'b1; e.done = 1'b1;
        push(1'b0, 1'b0, e);
      end
      4: begin
        e = blank(imm); e.a = 2'b10; e.alu = 3'b001; e.pc_write = z; e.done = 1'b1;
        push(1'b0, 1'b0, e);
      end
      5: begin
        e = blank(imm); e.a = 2'b01; e.b = 2'b10; e.pc_write = 1'b1;
        push(1'b0, 1'b0, e);
        e = blank(imm); e.reg_write = 1'b1; e.done = 1'b1;
        push(1'b0, 1'b0, e);
      end
      default: begin
        e = blank(imm); e.ill = 1'b1;
        for (int i = 0; i < ill_cycles; i++) push(1'b0, 1'b0, e);
      end
    endcase
  endtask

  // ---------------- drivers ----------------
  task automatic set_ir(input logic [31:0] ir, input logic z);
    op = ir[6:0]; funct3 = ir[14:12]; funct7b5 = ir[30]; zero = z;
  endtask

  task automatic run_q(input string nm, output int done_at);
    done_at = -1;
    for (int i = 0; i < q.size(); i++) begin
      mif.mem_ready = q[i].care ? q[i].mr : 1'($urandom);
      @(negedge clk);
      chk(nm, q[i].e);
      if (done_at < 0 && instr_done) done_at = i + 1;
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic exec(input string nm, input logic [31:0] ir, input logic z, input int fw,
                      input int mw, input int ill_cycles, output int done_at);
    set_ir(ir, z);
    build(ir, z, fw, mw, ill_cycles);
    run_q(nm, done_at);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      zero = 1'($urandom); mif.mem_ready = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", '0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  vec_t tbl[12];

  initial begin
    int d;
    int c;
    logic [31:0] ir;
    logic [6:0]  opl[6];

    tbl[0]  = '{"sub_r",      32'h402081B3, 1'b0, 0, 0, 4};
    tbl[1]  = '{"lw_wait2",   32'h00402283, 1'b0, 0, 2, 7};
    tbl[2]  = '{"beq_taken",  32'h00208463, 1'b1, 0, 0, 3};
    tbl[3]  = '{"beq_not",    32'h00208463, 1'b0, 0, 0, 3};
    tbl[4]  = '{"sw",         32'h0050A223, 1'b0, 0, 0, 4};
    tbl[5]  = '{"sw_waits",   32'h0050A223, 1'b0, 1, 1, 6};
    tbl[6]  = '{"addi",       32'h00100093, 1'b0, 0, 0, 4};
    tbl[7]  = '{"jal",        32'h008000EF, 1'b0, 0, 0, 4};
    tbl[8]  = '{"or_r",       32'h0020E1B3, 1'b0, 0, 0, 4};
    tbl[9]  = '{"and_r",      32'h0020F1B3, 1'b0, 0, 0, 4};
    tbl[10] = '{"slt_r",      32'h0020A1B3, 1'b0, 0, 0, 4};
    tbl[11] = '{"lw_fwait2",  32'h00402283, 1'b0, 2, 0, 7};

    mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(3);

    for (int i = 0; i < 12; i++) begin
      exec(tbl[i].nm, tbl[i].ir, tbl[i].z, tbl[i].fw, tbl[i].mw, 0, d);
      chk_int({"len_", tbl[i].nm}, d, tbl[i].cycles);
    end

    // Illegal opcode: sticks for 20 cycles, then reset brings fetch back.
    exec("illegal_op", 32'h0000007F, 1'b0, 0, 0, 20, d);
    chk_int("illegal_no_done", d, -1);
    do_reset(1);
    exec("after_illegal", 32'h402081B3, 1'b0, 0, 0, 0, d);
    chk_int("len_after_illegal", d, 4);

    // R-type with unsupported funct3 is also illegal.
    exec("illegal_f3", 32'h0020D1B3, 1'b0, 0, 0, 5, d);
    do_reset(1);

    // Reset while a store waits in MEMWRITE: no write strobe, resume at fetch.
    set_ir(32'h0050A223, 1'b0);
    build(32'h0050A223, 1'b0, 0, 1, 0);
    while (q.size() > 3) void'(q.pop_back());
    run_q("sw_prefix", d);
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_in_memwrite", '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exec("sw_after_reset", 32'h0050A223, 1'b0, 0, 0, 0, d);
    chk_int("len_sw_after_reset", d, 4);

    // Randomized instruction stream.
    opl[0] = 7'b0000011; opl[1] = 7'b0100011; opl[2] = 7'b0110011;
    opl[3] = 7'b0010011; opl[4] = 7'b1100011; opl[5] = 7'b1101111;
    for (int n = 0; n < 300; n++) begin
      int k;
      k  = $urandom_range(0, 19);
      ir = $urandom;
      ir[6:0] = (k == 0) ? 7'($urandom) : opl[$urandom_range(0, 5)];
      if (ir[6:0] == 7'b1100011 && k != 1) ir[14:12] = 3'b000;
      c = cls(ir[6:0], ir[14:12]);
      exec("random", ir, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 3, d);
      if (c == 6) do_reset(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, register file and unified instruction/data memory across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. It issues per-cycle mux selects and write enables, and waits on a memory ready handshake. The block sits between the instruction register and the datapath, and contains the ALU-control decode as a sub-module.

## Interface
- No parameters; widths fixed by RV32I.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `op` in 7: instruction register bits [6:0].
- `funct3` in 3: instruction register bits [14:12].
- `funct7b5` in 1: instruction register bit 30.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_req` out 1: memory access requested.
- `mem_write` out 1: store strobe; qualified by `mem_ready`.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR and OldPC.
- `pc_write` out 1: PC enable.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2: ALU B select; 00 = rs2, 01 = imm, 10 = const 4.
- `result_src` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALU result.
- `imm_src` out 2: immediate format; I = 00, S = 01, B = 10, J = 11.
- `alu_ctrl` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `instr_done` out 1: one-cycle pulse on each instruction's final cycle.
- `illegal` out 1: sticky; high while in ILLEGAL.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
- Outputs are a Moore decode of the state. Exceptions: `pc_write` in BEQ, and handshake-qualified strobes.
- Every output not listed for a state is 0.
- FETCH:
  - `mem_req`=1, `adr_src`=0, A=00, B=10, `result_src`=10, ALU add.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, go to DECODE.
  - Otherwise hold with no enables.
- DECODE: A=01, B=01, add (branch target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Any other opcode → ILLEGAL.
  - R/I with `funct3` outside {000, 010, 110, 111} → ILLEGAL.
  - BEQ with `funct3`≠000 → ILLEGAL.
- MEMADR: A=10, B=01, add. Go to MEMREAD if `op`[5]=0, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `instr_done`=1, go to FETCH.
- MEMWRITE: `mem_req`=1, `adr_src`=1, `mem_write`=`mem_ready`. On ready: `instr_done`=1, go to FETCH.
- EXECR: A=10, B=00, ALU-decode op. Go to ALUWB.
- EXECI: A=10, B=01, ALU-decode op. Go to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1, go to FETCH.
- BEQ: A=10, B=00, sub, `result_src`=00, `pc_write`=`zero`, `instr_done`=1, go to FETCH.
- JAL: A=01, B=10, add, `result_src`=00, `pc_write`=1. Go to ALUWB (writes PC+4 to rd).
- ILLEGAL: all enables 0, `illegal`=1. Stays in ILLEGAL until reset.
- `imm_src` is decoded from `op` in every state:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - Otherwise → 00.
- ALU decode:
  - alu_op 00 → add.
  - alu_op 01 → sub.
  - alu_op 10, by `funct3`:
    - 000 → sub iff `op`[5] & `funct7b5`, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.

## Timing
- Reset:
  - A clock edge with `rst_n`=0 sets the state to FETCH.
  - While `rst_n`=0, every output is forced to 0, including `mem_req` and `illegal`.
  - Reset mid-instruction abandons it with no register or memory write.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - lw: 5 cycles.
  - sw, R, I, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle `mem_ready` is low in FETCH/MEMREAD/MEMWRITE adds one cycle.
- `mem_ready` is ignored when `mem_req`=0.
- `mem_req` and `adr_src` are stable throughout a wait.
- `instr_done` is exactly one pulse per retired instruction, never in ILLEGAL.

## Structure
- Package `ctrl_pkg`:
  - State enum `ctrl_state_t`.
  - Opcode constants.
  - alu_op, alu_ctrl, src-select and imm_src encodings.
- Sub-module `alu_decode`: combinational; (alu_op, `op`[5], `funct3`, `funct7b5`) → `alu_ctrl`.
- The parent holds the state register, next-state logic and output decode.

## Test plan
- Reset → outputs:
  - Hold `rst_n`=0 for 3 cycles → all outputs 0.
  - Release → `mem_req`=1, `adr_src`=0 in the first cycle.
- R-type `sub x3,x1,x2` (IR=0x402081B3), `mem_ready`=1:
  - States FETCH, DECODE, EXECR, ALUWB.
  - `alu_ctrl`=001 in EXECR.
  - `reg_write`=1 only in cycle 4.
- Load `lw x5,4(x0)` (0x00402283), `mem_ready` low 2 cycles in MEMREAD:
  - Total 7 cycles.
  - `adr_src`=1 during the wait.
  - `reg_write` with `result_src`=01 in the last cycle.
- Branch `beq` (0x00208463):
  - `zero`=1 → `pc_write`=1 in BEQ, 3 cycles.
  - Repeat with `zero`=0 → `pc_write`=0 in BEQ.
- Illegal opcode 0x0000007F:
  - After DECODE, `illegal`=1 and no enables.
  - Stays for 20 cycles.
  - Reset returns to FETCH.
- Reset in MEMWRITE while `mem_ready`=0 → no `mem_write` pulse, next state FETCH.
